// File: rtl/packet_receiver_pkg.sv
// packet_receiver_pkg: definitions shared by the UART packet link
// (receiver and transmitter).
//   PACKET_SIZE_DEFAULT   payload bytes per packet
//   CLKS_PER_BIT_DEFAULT  clk cycles per serial bit (100 MHz / 115200 baud)
//   ST_*                  assembly state encodings
//   CSUM_W                checksum byte width
package packet_receiver_pkg;

    localparam int unsigned PACKET_SIZE_DEFAULT  = 2;
    localparam int unsigned CLKS_PER_BIT_DEFAULT = 868;

    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] ST_IDLE     = 2'd0;
    localparam logic [STATE_W-1:0] ST_ASSEMBLE = 2'd1;
    localparam logic [STATE_W-1:0] ST_CHECK    = 2'd2;

    localparam int unsigned CSUM_W = 8;

endpackage

// File: rtl/packet_receiver_if.sv
// packet_receiver_if: completed-packet valid/ready handshake.
//   packet        completed packet word, first received byte in [7:0]
//   packet_valid  packet holds an unconsumed packet
//   packet_ready  consumer accepts when packet_valid & packet_ready
// Modports: master (producer side), slave (consumer side).
interface packet_receiver_if
    import packet_receiver_pkg::*;
#(
    parameter int unsigned WIDTH = PACKET_SIZE_DEFAULT * 8
) ();

    logic [WIDTH-1:0] packet;
    logic             packet_valid;
    logic             packet_ready;

    modport master (
        output packet,
        output packet_valid,
        input  packet_ready
    );

    modport slave (
        input  packet,
        input  packet_valid,
        output packet_ready
    );

endinterface

// File: rtl/packet_receiver_uart_rx.sv
// uart_rx_8n1: layer-2 8N1 serial receiver.
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   rxd    serial line in, idle high
//   data   last received byte (LSB first on the line)
//   valid  one-cycle strobe when data holds a new byte
// A frame with a bad start or stop bit is ignored.
module uart_rx_8n1
    import packet_receiver_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid
);

    localparam int unsigned CNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic [1:0]       sync;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // Two-flop synchroniser; sampling lands mid-bit because START waits half a bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync    <= 2'b11;
            st      <= RX_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shreg   <= '0;
            data    <= '0;
            valid   <= 1'b0;
        end else begin
            sync  <= {sync[0], rxd};
            valid <= 1'b0;
            case (st)
                RX_IDLE: begin
                    cnt <= '0;
                    if (!sync[1]) st <= RX_START;
                end
                RX_START: begin
                    if (cnt == HALF_END) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        st      <= sync[1] ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_END) begin
                        cnt     <= '0;
                        shreg   <= {sync[1], shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) st <= RX_STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_END) begin
                        cnt <= '0;
                        st  <= RX_IDLE;
                        if (sync[1]) begin
                            data  <= shreg;
                            valid <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: st <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/packet_receiver.sv
// packet_receiver: layer-3 receive side of the UART packet link. Assembles
// PACKET_SIZE bytes from uart_rx_8n1 into one word (first byte in [7:0]) and
// presents it on a valid/ready handshake.
//   clk, rst_n    system clock, asynchronous active-low reset
//   rxd           serial line in (8N1, idle high)
//   pkt_if        master modport: packet, packet_valid, packet_ready
//   overrun       sticky: a completed packet was dropped, output still full
//   timeout       one-cycle pulse when a stale partial packet is discarded
//   checksum_err  one-cycle pulse on checksum mismatch (0 without the feature)
// Build option PACKET_RX_CHECKSUM_EN: a trailing XOR-of-payload byte is
// expected after the payload and checked before the packet is delivered.
module packet_receiver
    import packet_receiver_pkg::*;
#(
    parameter int unsigned PACKET_SIZE    = PACKET_SIZE_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 32'd100000,
    parameter int unsigned CLKS_PER_BIT   = CLKS_PER_BIT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rxd,
    packet_receiver_if.master pkt_if,
    output logic              overrun,
    output logic              timeout,
    output logic              checksum_err
);

    localparam int unsigned W     = PACKET_SIZE * 8;
    localparam int unsigned IDX_W = $clog2(PACKET_SIZE + 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PACKET_SIZE - 1);

    logic [7:0]         rx_data;
    logic               rx_valid;

    logic [STATE_W-1:0] state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [W-1:0]       asm_buf, asm_n, asm_wr, done_word;
    logic [31:0]        tmr, tmr_n;
    logic               complete, timeout_n, cerr_n;
    logic [W-1:0]       packet_r;
    logic               valid_r;
    logic               hs;

`ifdef PACKET_RX_CHECKSUM_EN
    logic [CSUM_W-1:0]  csum, csum_n;
`endif

    uart_rx_8n1 #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk  (clk),
        .rst_n(rst_n),
        .rxd  (rxd),
        .data (rx_data),
        .valid(rx_valid)
    );

    always_comb begin
        state_n   = state;
        idx_n     = idx;
        asm_n     = asm_buf;
        tmr_n     = tmr;
        complete  = 1'b0;
        timeout_n = 1'b0;
        cerr_n    = 1'b0;
        asm_wr    = asm_buf;
        done_word = asm_buf;
`ifdef PACKET_RX_CHECKSUM_EN
        csum_n    = csum;
`endif
        for (int unsigned k = 0; k < PACKET_SIZE; k++) begin
            if (idx == IDX_W'(k)) asm_wr[k*8 +: 8] = rx_data;
        end

        if (rx_valid) begin
            // A byte always wins over an expiring timer on the same cycle.
            tmr_n = '0;
`ifdef PACKET_RX_CHECKSUM_EN
            if (state == ST_CHECK) begin
                if (rx_data == csum) complete = 1'b1;
                else                 cerr_n   = 1'b1;
                state_n = ST_IDLE;
                idx_n   = '0;
                asm_n   = '0;
                csum_n  = '0;
            end else begin
                state_n = (idx == LAST_IDX) ? ST_CHECK : ST_ASSEMBLE;
                idx_n   = idx + IDX_W'(1);
                asm_n   = asm_wr;
                csum_n  = csum ^ rx_data;
            end
`else
            if (idx == LAST_IDX) begin
                complete  = 1'b1;
                done_word = asm_wr;
                state_n   = ST_IDLE;
                idx_n     = '0;
                asm_n     = '0;
            end else begin
                state_n = ST_ASSEMBLE;
                idx_n   = idx + IDX_W'(1);
                asm_n   = asm_wr;
            end
`endif
        end else if (state != ST_IDLE) begin
            if (tmr == TIMEOUT_CYCLES - 1) begin
                timeout_n = 1'b1;
                state_n   = ST_IDLE;
                idx_n     = '0;
                asm_n     = '0;
                tmr_n     = '0;
`ifdef PACKET_RX_CHECKSUM_EN
                csum_n    = '0;
`endif
            end else begin
                tmr_n = tmr + 32'd1;
            end
        end
    end

    assign hs = valid_r & pkt_if.packet_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            idx      <= '0;
            asm_buf  <= '0;
            tmr      <= '0;
            packet_r <= '0;
            valid_r  <= 1'b0;
            overrun  <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state   <= state_n;
            idx     <= idx_n;
            asm_buf <= asm_n;
            tmr     <= tmr_n;
            timeout <= timeout_n;
            // A completion landing on the handshake cycle replaces the
            // consumed word and keeps valid high.
            if (complete && (!valid_r || hs)) begin
                packet_r <= done_word;
                valid_r  <= 1'b1;
            end else begin
                if (complete) overrun <= 1'b1;
                if (hs)       valid_r <= 1'b0;
            end
        end
    end

`ifdef PACKET_RX_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csum         <= '0;
            checksum_err <= 1'b0;
        end else begin
            csum         <= csum_n;
            checksum_err <= cerr_n;
        end
    end
`else
    assign checksum_err = 1'b0;
`endif

    assign pkt_if.packet       = packet_r;
    assign pkt_if.packet_valid = valid_r;

endmodule

// File: doc/packet_receiver.md
Name: packet_receiver

Overview:
- Layer-3 receive side of the UART packet link: assembles PACKET_SIZE consecutive bytes from the layer-2 8N1 receiver into one packet word.
- Byte order matches the packet transmitter: first byte received lands in packet[7:0], byte k lands in packet[k*8+:8].
- Presents completed packets on a valid/ready handshake.
- Discards stale partial packets after an inter-byte timeout, so the link resynchronises after a dropped byte.

Parameters:
- PACKET_SIZE, 16'd2: payload bytes per packet (>=1).
- TIMEOUT_CYCLES, 32'd100000: clk cycles without a new byte before a partial packet is discarded (>=2).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- rxd  in  1  serial line in (8N1, idle high).
- packet  out  PACKET_SIZE*8  last completed packet, LSB byte = first received.
- packet_valid  out  1  packet holds an unconsumed packet.
- packet_ready  in  1  consumer accepts packet when packet_valid & packet_ready.
- overrun  out  1  sticky: a completed packet was dropped because the output was still full.
- timeout  out  1  one-cycle pulse when a partial packet is discarded.
- checksum_err  out  1  one-cycle pulse on a checksum mismatch (tied 0 without the feature).

Behaviour:
- Reset: one clock domain; rst_n is asynchronous and active-low. While rst_n is low: packet=0, packet_valid=0, overrun=0, timeout=0, checksum_err=0, byte index=0, assembly buffer=0, timeout counter=0.
- Reset mid-packet aborts assembly with no pulses.
- Byte input: uart_rx_8n1 delivers rx_data[7:0] with a single-cycle rx_valid strobe. Each strobe writes rx_data to assembly byte[idx] and increments idx.
- Completion, on the cycle the final byte strobe is seen (idx == PACKET_SIZE-1):
  - If packet_valid==0, or the handshake fires that same cycle: on the next clk edge, packet <= assembled word, packet_valid <= 1, idx <= 0. Latency is 1 cycle from the final rx_valid to packet_valid.
  - Otherwise the new packet is dropped, overrun <= 1 (cleared only by reset), idx <= 0, and packet keeps its old value.
- Handshake: packet_valid stays high until packet_valid & packet_ready, then clears on the next edge unless a new packet completes in that same cycle, in which case it stays high with the new data. packet is stable while packet_valid=1.
- Timeout: counter clears on every rx_valid and only runs while idx != 0. When it reaches TIMEOUT_CYCLES-1: idx <= 0, assembly discarded, timeout pulses for 1 cycle. A byte arriving on that same cycle wins: the counter clears and there is no timeout.
- States: IDLE (idx=0), ASSEMBLE (0<idx<PACKET_SIZE), plus CHECK when the feature is enabled. An output-full condition does not stall assembly.

Optional Feature:
- Macro: PACKET_RX_CHECKSUM_EN.
- Enabled:
  - After PACKET_SIZE payload bytes, one extra byte (state CHECK) is expected, equal to the XOR of all payload bytes.
  - Match: completes exactly as above.
  - Mismatch: packet discarded, checksum_err pulses 1 cycle, idx <= 0, no overrun update.
  - Timeout applies during CHECK.
- Disabled: no CHECK state, no XOR logic, checksum_err constant 0.

Decomposition:
- Shared package/header packet_defs:
  - default PACKET_SIZE;
  - state encodings IDLE/ASSEMBLE/CHECK;
  - checksum byte width (8).
  - The same header is reused by the transmitter.
- One natural sub-module: uart_rx_8n1, the existing layer-2 receiver (ports clk, rxd, data[7:0], valid). packet_receiver instantiates it once.

Test Plan (drive rxd with 8N1 frames; PACKET_SIZE=2; TIMEOUT_CYCLES=64 for sim):
- Send 0x41 then 0x42, packet_ready=1 -> packet_valid high for 1 cycle, 1 cycle after the second rx_valid, with packet=16'h4241; timeout, overrun and checksum_err stay 0.
- Hold packet_ready=0, send 0x01,0x02 then 0x03,0x04 -> packet=16'h0201 held, packet_valid stays 1, overrun=1. Raise ready -> valid clears, packet unchanged.
- Send 0x11, then idle 64+ cycles, then send 0x22,0x33 -> one timeout pulse, then packet=16'h3322.
- Assert rst_n=0 asynchronously mid-frame after one byte; release; send 0xAA,0xBB -> all outputs 0 during reset, then packet=16'hBBAA.
- With PACKET_RX_CHECKSUM_EN: send 0x0F,0xF0,0xFF -> packet=16'hF00F valid. Send 0x0F,0xF0,0x00 -> checksum_err pulse, packet_valid stays 0.
- With ready toggling: send back-to-back packets so completion coincides with the handshake cycle -> packet_valid stays 1, packet takes the new value, no overrun.
